// File: rtl/piso_shift_feeder.sv
// piso_shift_feeder: buffers up to two parallel words and streams them
// bit-serially into a downstream SIPO with a per-word shift enable.
module piso_shift_feeder #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ShiftEn,
    output logic             ShiftIn,
    output logic             word_done,
    output logic             busy
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [3:0] LAST_GAP =
        HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] fifoMem [2];
    logic             wrPtr, rdPtr;
    logic [1:0]       fifoCount, countNext;
    logic             push, pop, doLoad;
    logic [WIDTH-1:0] headWord, shreg, shregNext;
    logic [BW-1:0]    bitCnt, bitCntNext;
    logic [3:0]       gapCnt, gapCntNext;
    logic             shiftEnNext, shiftInNext;
    logic             wordDoneNext, busyNext;

    function automatic logic bitOf(
        input logic [WIDTH-1:0] w,
        input logic [BW-1:0]    idx
    );
        logic [BW-1:0] pos;
        pos = MSB_FIRST ? LAST_BIT - idx : idx;
        return w[pos];
    endfunction

    assign in_ready = ~rst & (fifoCount != 2'd2);
    assign push     = in_valid & in_ready;
    assign pop      = doLoad;
    assign headWord = fifoMem[rdPtr];

    assign countNext = fifoCount + {1'b0, push} - {1'b0, pop};

    always_comb begin
        stateNext    = state;
        shregNext    = shreg;
        bitCntNext   = bitCnt;
        gapCntNext   = gapCnt;
        shiftEnNext  = 1'b0;
        shiftInNext  = 1'b0;
        wordDoneNext = 1'b0;
        doLoad       = 1'b0;
        unique case (state)
            IDLE: begin
                doLoad = (fifoCount != 2'd0);
            end
            SHIFT: begin
                if (bitCnt == LAST_BIT) begin
                    wordDoneNext = 1'b1;
                    if (HAS_GAP) begin
                        stateNext  = GAP;
                        gapCntNext = 4'd0;
                    end else if (fifoCount != 2'd0) begin
                        doLoad = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    bitCntNext  = bitCnt + 1'b1;
                    shiftEnNext = 1'b1;
                    shiftInNext = bitOf(shreg, bitCntNext);
                end
            end
            GAP: begin
                if (gapCnt == LAST_GAP) begin
                    if (fifoCount != 2'd0) doLoad = 1'b1;
                    else                   stateNext = IDLE;
                end else begin
                    gapCntNext = gapCnt + 4'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // A load always starts a fresh word, whichever state it comes from
        if (doLoad) begin
            stateNext   = SHIFT;
            shregNext   = headWord;
            bitCntNext  = '0;
            shiftEnNext = 1'b1;
            shiftInNext = bitOf(headWord, '0);
        end
    end

    assign busyNext = (stateNext != IDLE) | (countNext != 2'd0);

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            fifoCount <= 2'd0;
            shreg     <= '0;
            bitCnt    <= '0;
            gapCnt    <= 4'd0;
            ShiftEn   <= 1'b0;
            ShiftIn   <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            wrPtr     <= wrPtr ^ push;
            rdPtr     <= rdPtr ^ pop;
            fifoCount <= countNext;
            shreg     <= shregNext;
            bitCnt    <= bitCntNext;
            gapCnt    <= gapCntNext;
            ShiftEn   <= shiftEnNext;
            ShiftIn   <= shiftInNext;
            word_done <= wordDoneNext;
            busy      <= busyNext;
        end
    end
endmodule

// File: tb/tb_piso_shift_feeder.sv
// tb_piso_shift_feeder: two feeder configurations against a bit-schedule
// reference model, with a software SIPO rebuilding each delivered word.
module tb_piso_shift_feeder;
    localparam int W = 4;
    localparam int GAP_A = 0;
    localparam int GAP_B = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inValid = 1'b0;
    logic [3:0] inData = 4'd0;
    logic [1:0] rdy, en, sin, done, bsy;

    piso_shift_feeder #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP_A)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy[0]),
        .in_data(inData), .ShiftEn(en[0]), .ShiftIn(sin[0]),
        .word_done(done[0]), .busy(bsy[0])
    );

    piso_shift_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP_B)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy[1]),
        .in_data(inData), .ShiftEn(en[1]), .ShiftIn(sin[1]),
        .word_done(done[1]), .busy(bsy[1])
    );

    always #5 clk = ~clk;

    // model: pending words plus the word currently being played out,
    // as a schedule of W bit slots followed by gap slots
    logic [3:0] mf [2][2];
    int         mCnt [2];
    logic [3:0] sWord [2];
    int         sPos [2];
    bit         sActive [2];
    bit         pushed [2];
    bit         expEn [2], expIn [2], expDone [2], expBusy [2];
    logic [3:0] doneWord [2];
    logic [3:0] sipo [2];
    logic [3:0] stallWords [3];
    int         checks, failures;

    task automatic checkEq(input string tag, input logic [3:0] got,
                           input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input int k);
        int gap;
        bit msb;
        logic [1:0] bi;
        gap = (k == 0) ? GAP_A : GAP_B;
        msb = (k == 0);
        if (rst) begin
            mCnt[k] = 0;
            sActive[k] = 0;
            sPos[k] = 0;
            pushed[k] = 0;
            expEn[k] = 0;
            expIn[k] = 0;
            expDone[k] = 0;
            expBusy[k] = 0;
            return;
        end
        pushed[k] = inValid && (mCnt[k] < 2);
        expDone[k] = sActive[k] && (sPos[k] == W - 1);
        if (expDone[k]) doneWord[k] = sWord[k];
        if (sActive[k]) begin
            sPos[k]++;
            if (sPos[k] == W + gap) sActive[k] = 0;
        end
        if (!sActive[k] && mCnt[k] > 0) begin
            sWord[k] = mf[k][0];
            mf[k][0] = mf[k][1];
            mCnt[k]--;
            sActive[k] = 1;
            sPos[k] = 0;
        end
        if (pushed[k]) begin
            mf[k][mCnt[k]] = inData;
            mCnt[k]++;
        end
        expEn[k] = sActive[k] && (sPos[k] < W);
        bi = msb ? 2'(W - 1 - sPos[k]) : 2'(sPos[k]);
        expIn[k] = expEn[k] ? sWord[k][bi] : 1'b0;
        expBusy[k] = sActive[k] || (mCnt[k] > 0);
    endtask

    task automatic checkCycle(input int k);
        checkEq($sformatf("in_ready%0d", k), 4'(rdy[k]),
                4'(!rst && mCnt[k] < 2));
        checkEq($sformatf("ShiftEn%0d", k), 4'(en[k]), 4'(expEn[k]));
        checkEq($sformatf("ShiftIn%0d", k), 4'(sin[k]), 4'(expIn[k]));
        checkEq($sformatf("word_done%0d", k), 4'(done[k]), 4'(expDone[k]));
        checkEq($sformatf("busy%0d", k), 4'(bsy[k]), 4'(expBusy[k]));
        if (expDone[k])
            checkEq($sformatf("ParallelOut%0d", k), sipo[k], doneWord[k]);
        if (en[k]) begin
            if (k == 0) sipo[k] = {sipo[k][2:0], sin[k]};
            else        sipo[k] = {sin[k], sipo[k][3:1]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        @(negedge clk);
        checkCycle(0);
        checkCycle(1);
    endtask

    task automatic drive(input bit v, input logic [3:0] d);
        inValid = v;
        inData = d;
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        stallWords[0] = 4'h1;
        stallWords[1] = 4'h2;
        stallWords[2] = 4'h3;
        for (int k = 0; k < 2; k++) begin
            mCnt[k] = 0;
            sActive[k] = 0;
            sPos[k] = 0;
            sWord[k] = 4'd0;
            sipo[k] = 4'd0;
            doneWord[k] = 4'd0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        drive(1, 4'hB); tick();
        drive(0, 4'h0); repeat (10) tick();

        drive(1, 4'hA); tick();
        drive(1, 4'h5); tick();
        drive(0, 4'h0); repeat (16) tick();

        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            drive(1, stallWords[n]);
            tick();
            if (pushed[0]) n++;
        end
        checkEq("stallAccepts", 4'(n), 4'd3);
        drive(0, 4'h0); repeat (24) tick();

        drive(1, 4'hF); tick();
        drive(1, 4'h0); tick();
        drive(0, 4'h0); repeat (16) tick();

        drive(1, 4'hC); tick();
        drive(1, 4'h3); tick();
        drive(0, 4'h0); tick();
        rst = 1'b1; tick();
        rst = 1'b0; repeat (12) tick();

        repeat (600) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
            tick();
        end
        rst = 1'b0;
        drive(0, 4'h0);
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
